clock_ctrl: RTL and testbench

- Timekeeping and settings controller for the alarm clock.
- Sequences the seconds/minutes/hours counting chain from a 1 Hz enable pulse.
- Runs a mode FSM, driven by pre-debounced single-cycle button pulses, for setting the time and the alarm.
- Raises the alarm ring output.
- Sits between the button debouncers and the 7-segment display mux; the display takes disp_hr/disp_min/blink from this block.

---
 rtl/clock_ctrl.sv | 151 +++++++++++++++
 tb/tb_clock_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Alarm-clock timekeeping core: h:m:s counting chain, set/alarm mode FSM,
// alarm arming and ring timing. Buttons arrive pre-debounced as 1-cycle pulses.
module clock_ctrl #(
    parameter int unsigned SEC_MAX    = 59,
    parameter int unsigned MIN_MAX    = 59,
    parameter int unsigned HR_MAX     = 23,
    parameter int unsigned RING_TICKS = 60
) (
    input  logic       ctrl_clk,
    input  logic       ctrl_rst,
    input  logic       ctrl_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    output logic [4:0] hr_out,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic [4:0] disp_hr,
    output logic [5:0] disp_min,
    output logic [2:0] mode,
    output logic       blink,
    output logic       alarm_on,
    output logic       ring
);

    localparam int unsigned RW = $clog2(RING_TICKS + 1);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] SET_HR  = 3'd1;
    localparam logic [2:0] SET_MIN = 3'd2;
    localparam logic [2:0] AL_HR   = 3'd3;
    localparam logic [2:0] AL_MIN  = 3'd4;

    localparam logic [5:0]    SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0]    MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0]    HR_LAST   = 5'(HR_MAX);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_TICKS);

    logic [4:0]    hr_q, hr_d, al_hr_q, al_hr_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
    logic [2:0]    mode_q, mode_d;
    logic          alarm_on_q, alarm_on_d, ring_q, ring_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;

    logic counting;
    logic advance;
    logic dismiss;

    always_comb begin
        hr_d       = hr_q;
        min_d      = min_q;
        sec_d      = sec_q;
        al_hr_d    = al_hr_q;
        al_min_d   = al_min_q;
        mode_d     = mode_q;
        alarm_on_d = alarm_on_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;

        counting = (mode_q == RUN) || (mode_q == AL_HR) || (mode_q == AL_MIN);
        // While ringing, btn_mode is spent on dismissal and never advances the FSM.
        advance  = btn_mode && !ring_q;
        dismiss  = ring_q && (btn_mode || btn_alarm);

        if (counting && ctrl_tick) begin
            if (sec_q == SEC_LAST) begin
                sec_d = '0;
                if (min_q == MIN_LAST) begin
                    min_d = '0;
                    hr_d  = (hr_q == HR_LAST) ? '0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (btn_inc && !btn_mode) begin
            case (mode_q)
                SET_HR:  hr_d     = (hr_q == HR_LAST)     ? '0 : hr_q + 5'd1;
                SET_MIN: min_d    = (min_q == MIN_LAST)   ? '0 : min_q + 6'd1;
                AL_HR:   al_hr_d  = (al_hr_q == HR_LAST)  ? '0 : al_hr_q + 5'd1;
                AL_MIN:  al_min_d = (al_min_q == MIN_LAST) ? '0 : al_min_q + 6'd1;
                default: ;
            endcase
        end

        if (advance) begin
            mode_d = (mode_q == AL_MIN) ? RUN : mode_q + 3'd1;
            if (mode_q == RUN) begin
                sec_d = '0;
            end
        end

        if (btn_alarm && !ring_q) begin
            alarm_on_d = ~alarm_on_q;
        end

        if (ring_q) begin
            if (dismiss) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else if (ctrl_tick) begin
                ring_cnt_d = ring_cnt_q - 1'b1;
                if (ring_cnt_q == RW'(1)) begin
                    ring_d = 1'b0;
                end
            end
        end else if (mode_q == RUN && !btn_mode && alarm_on_q && ctrl_tick &&
                     hr_d == al_hr_q && min_d == al_min_q && sec_d == '0) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
        end
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            hr_q       <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            al_hr_q    <= '0;
            al_min_q   <= '0;
            mode_q     <= RUN;
            alarm_on_q <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            al_hr_q    <= al_hr_d;
            al_min_q   <= al_min_d;
            mode_q     <= mode_d;
            alarm_on_q <= alarm_on_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign hr_out   = hr_q;
    assign min_out  = min_q;
    assign sec_out  = sec_q;
    assign mode     = mode_q;
    assign alarm_on = alarm_on_q;
    assign ring     = ring_q;
    assign blink    = (mode_q == SET_HR) || (mode_q == AL_HR);
    assign disp_hr  = (mode_q == AL_HR || mode_q == AL_MIN) ? al_hr_q  : hr_q;
    assign disp_min = (mode_q == AL_HR || mode_q == AL_MIN) ? al_min_q : min_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scenario bench for clock_ctrl: expected output snapshots are queued as
// stimulus is driven and compared once the DUT has clocked the inputs.
module tb_clock_ctrl;

    logic       ctrl_clk = 1'b0;
    logic       ctrl_rst = 1'b0;
    logic       ctrl_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_alarm = 1'b0;
    logic [4:0] hr_out, disp_hr;
    logic [5:0] min_out, sec_out, disp_min;
    logic [2:0] mode;
    logic       blink, alarm_on, ring;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mi;
        logic [5:0] se;
        logic [2:0] mo;
        logic       bl;
        logic       ao;
        logic       rg;
        logic [4:0] dh;
        logic [5:0] dm;
    } snap_t;

    snap_t sb[$];
    snap_t got, want;
    int n_chk = 0;
    int n_fail = 0;

    clock_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .HR_MAX(23), .RING_TICKS(60)) dut (
        .ctrl_clk(ctrl_clk), .ctrl_rst(ctrl_rst), .ctrl_tick(ctrl_tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .hr_out(hr_out), .min_out(min_out), .sec_out(sec_out),
        .disp_hr(disp_hr), .disp_min(disp_min), .mode(mode),
        .blink(blink), .alarm_on(alarm_on), .ring(ring)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic snap_t snap();
        return snap_t'({hr_out, min_out, sec_out, mode, blink, alarm_on, ring, disp_hr, disp_min});
    endfunction

    function automatic snap_t mk(int h, int m, int s, int mo, int ao, int rg, int dh, int dm);
        snap_t r;
        r.hr = 5'(h); r.mi = 6'(m); r.se = 6'(s); r.mo = 3'(mo);
        r.bl = (mo == 1) || (mo == 3);
        r.ao = 1'(ao); r.rg = 1'(rg); r.dh = 5'(dh); r.dm = 6'(dm);
        return r;
    endfunction

    task automatic step();
        @(posedge ctrl_clk);
        @(negedge ctrl_clk);
    endtask

    task automatic press_mode(int n);
        for (int i = 0; i < n; i++) begin
            btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
        end
    endtask

    task automatic press_inc(int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1; step(); btn_inc = 1'b0; step();
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            ctrl_tick = 1'b1; step(); ctrl_tick = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        ctrl_rst = 1'b1; btn_mode = 1'b1; ctrl_tick = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(); step();
        ctrl_rst = 1'b0; btn_mode = 1'b0; ctrl_tick = 1'b0;
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, want); end

        sb.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
        ticks(3);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL three_ticks: got %h want %h", got, want); end
    endtask

    task automatic test_set_time();
        sb.push_back(mk(23, 0, 0, 1, 0, 0, 23, 0));
        press_mode(1); press_inc(23);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL set_hr23: got %h want %h", got, want); end

        sb.push_back(mk(23, 59, 0, 2, 0, 0, 23, 59));
        press_mode(1); press_inc(59);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL set_min59: got %h want %h", got, want); end

        sb.push_back(mk(23, 59, 0, 3, 0, 0, 0, 0));
        press_mode(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL al_hr_disp: got %h want %h", got, want); end

        sb.push_back(mk(23, 59, 0, 0, 0, 0, 23, 59));
        press_mode(2);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL back_run: got %h want %h", got, want); end

        sb.push_back(mk(23, 59, 1, 0, 0, 0, 23, 59));
        ctrl_tick = 1'b1; step(); ctrl_tick = 1'b0;
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL tick_latency: got %h want %h", got, want); end

        step();
        sb.push_back(mk(23, 59, 59, 0, 0, 0, 23, 59));
        ticks(58);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL preload_235959: got %h want %h", got, want); end

        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        ticks(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL day_wrap: got %h want %h", got, want); end
    endtask

    task automatic test_freeze();
        press_mode(1); press_inc(5); press_mode(1); press_inc(59);
        sb.push_back(mk(5, 59, 0, 2, 0, 0, 5, 59));
        for (int i = 0; i < 10; i++) begin
            ctrl_tick = 1'b1; step(); ctrl_tick = 1'b0;
            for (int j = 0; j < 9; j++) step();
        end
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL set_freeze: got %h want %h", got, want); end

        sb.push_back(mk(5, 0, 0, 2, 0, 0, 5, 0));
        press_inc(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL min_wrap_nocarry: got %h want %h", got, want); end

        press_mode(3);
    endtask

    task automatic test_priority();
        int exp_mode;
        for (int k = 0; k < 4; k++) begin
            exp_mode = k + 1;
            if (exp_mode >= 3) sb.push_back(mk(5, 0, 0, exp_mode, 0, 0, 0, 0));
            else sb.push_back(mk(5, 0, 0, exp_mode, 0, 0, 5, 0));
            btn_mode = 1'b1; btn_inc = 1'b1; step(); btn_mode = 1'b0; btn_inc = 1'b0; step();
            want = sb.pop_front(); got = snap(); n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL mode_beats_inc[%0d]: got %h want %h", k, got, want); end
        end

        sb.push_back(mk(5, 0, 1, 4, 0, 0, 0, 1));
        ctrl_tick = 1'b1; btn_inc = 1'b1; step(); ctrl_tick = 1'b0; btn_inc = 1'b0; step();
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL al_tick_and_inc: got %h want %h", got, want); end

        sb.push_back(mk(5, 0, 1, 0, 0, 0, 5, 0));
        press_mode(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL al_min_to_run: got %h want %h", got, want); end
    endtask

    task automatic test_alarm();
        press_mode(1); press_inc(1); press_mode(1); press_inc(29);
        press_mode(1); press_inc(6); press_mode(1); press_inc(29);
        sb.push_back(mk(6, 29, 0, 4, 0, 0, 6, 30));
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL alarm_set_0630: got %h want %h", got, want); end

        press_mode(1);
        sb.push_back(mk(6, 29, 0, 0, 1, 0, 6, 29));
        btn_alarm = 1'b1; step(); btn_alarm = 1'b0; step();
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL arm: got %h want %h", got, want); end

        sb.push_back(mk(6, 29, 59, 0, 1, 0, 6, 29));
        ticks(59);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL pre_trigger: got %h want %h", got, want); end

        sb.push_back(mk(6, 30, 0, 0, 1, 1, 6, 30));
        ctrl_tick = 1'b1; step(); ctrl_tick = 1'b0;
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL ring_same_edge: got %h want %h", got, want); end
        step();

        sb.push_back(mk(6, 30, 59, 0, 1, 1, 6, 30));
        ticks(59);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL ring_tick59: got %h want %h", got, want); end

        sb.push_back(mk(6, 31, 0, 0, 1, 0, 6, 31));
        ticks(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL ring_tick60_off: got %h want %h", got, want); end

        press_mode(2); press_inc(58); press_mode(3);
        ticks(59);
        sb.push_back(mk(6, 30, 0, 0, 1, 1, 6, 30));
        ticks(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL retrigger_next_match: got %h want %h", got, want); end

        ticks(5);
        sb.push_back(mk(6, 30, 5, 0, 1, 0, 6, 30));
        btn_alarm = 1'b1; step(); btn_alarm = 1'b0; step();
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL dismiss: got %h want %h", got, want); end

        sb.push_back(mk(6, 30, 6, 0, 1, 0, 6, 30));
        ticks(1);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL stays_dismissed: got %h want %h", got, want); end
    endtask

    task automatic test_reset_mid_ring();
        press_mode(4); press_inc(1); press_mode(1);
        sb.push_back(mk(6, 30, 59, 0, 1, 0, 6, 30));
        ticks(59);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL pre_ring2: got %h want %h", got, want); end

        sb.push_back(mk(6, 31, 0, 0, 1, 1, 6, 31));
        ticks(1); press_inc(3);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL inc_ignored_ringing: got %h want %h", got, want); end

        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        ctrl_rst = 1'b1; btn_inc = 1'b1; ctrl_tick = 1'b1; btn_alarm = 1'b1;
        step();
        ctrl_rst = 1'b0; btn_inc = 1'b0; ctrl_tick = 1'b0; btn_alarm = 1'b0;
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL reset_mid_ring: got %h want %h", got, want); end

        press_inc(3);
        sb.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0));
        press_mode(3);
        want = sb.pop_front(); got = snap(); n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL alarm_regs_cleared: got %h want %h", got, want); end
        press_mode(2);
    endtask

    initial begin
        step();
        test_reset();
        test_set_time();
        test_freeze();
        test_priority();
        test_alarm();
        test_reset_mid_ring();
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
